// File: rtl/div_control_fsm.sv
// Sequencing controller for the multi-cycle non-restoring divider.
// Each quotient bit takes three cycles (SHIFT, OP, SETQ). After the last bit, one
// CORRECT cycle restores a negative remainder. The FSM then parks in DONE with
// ready high.
module div_control_fsm #(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic MSB,
  output logic add,
  output logic sub,
  output logic shiftQuotient,
  output logic Q0,
  output logic ready
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] OP      = 3'd2;
  localparam logic [2:0] SETQ    = 3'd3;
  localparam logic [2:0] CORRECT = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [2:0]    state, state_nx;
  logic [CW-1:0] count, count_nx;

  // Next-state and iteration-count logic; start overrides every other transition
  always_comb begin
    state_nx = state;
    count_nx = count;
    if (start) begin
      state_nx = SHIFT;
      count_nx = '0;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        SHIFT:   state_nx = OP;
        OP:      state_nx = SETQ;
        SETQ: begin
          count_nx = count + CW'(1);
          state_nx = (count_nx < LAST) ? SHIFT : CORRECT;
        end
        CORRECT: state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and counter registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // Datapath strobes; MSB only reaches outputs in OP, SETQ and CORRECT
  always_comb begin
    add           = 1'b0;
    sub           = 1'b0;
    shiftQuotient = 1'b0;
    Q0            = 1'b0;
    ready         = 1'b0;
    case (state)
      SHIFT:   shiftQuotient = 1'b1;
      OP: begin
        add = MSB;
        sub = ~MSB;
      end
      SETQ:    Q0    = ~MSB;
      CORRECT: add   = MSB;
      DONE:    ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_control_fsm.sv
// Self-checking bench for div_control_fsm.
// The reference model tracks only the number of edges since the last sampled start.
module tb_div_control_fsm;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset, start, MSB;
  logic add, sub, shiftQuotient, Q0, ready;

  int tests = 0;
  int fails = 0;
  int t     = -1;   // edges since the edge that sampled start; -1 = idle

  typedef struct {
    logic       s;
    logic       m;
    logic [4:0] exp;   // {add, sub, shiftQuotient, Q0, ready}
  } vec_t;

  vec_t vecs[12];

  always #5 clock = ~clock;

  div_control_fsm #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .MSB(MSB),
    .add(add),
    .sub(sub),
    .shiftQuotient(shiftQuotient),
    .Q0(Q0),
    .ready(ready)
  );

  // Outputs expected tt edges after start, given the current remainder sign m
  function automatic logic [4:0] model(input int tt, input logic m);
    if (tt < 0) return 5'b00000;
    if (tt < 3*W) begin
      case (tt % 3)
        0:       return 5'b00100;
        1:       return {m, ~m, 3'b000};
        default: return {3'b000, ~m, 1'b0};
      endcase
    end
    if (tt == 3*W) return {m, 4'b0000};
    return 5'b00001;
  endfunction

  function automatic logic [4:0] outs();
    return {add, sub, shiftQuotient, Q0, ready};
  endfunction

  task automatic chk(input string n, input logic [4:0] a, input logic [4:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0d) at %0t", n, a, e, t, $time);
    end
  endtask

  task automatic inv_chk(input string n);
    tests++;
    if ((add & sub) || (shiftQuotient & (add | sub | Q0))) begin
      fails++;
      $display("FAIL %s invariant: got add=%b sub=%b sh=%b q0=%b expected exclusive strobes",
               n, add, sub, shiftQuotient, Q0);
    end
  endtask

  function automatic void advance(input logic s);
    if (s) t = 0;
    else if (t >= 0 && t <= 3*W) t++;
  endfunction

  // One clock period: drive, check mid-cycle, take the edge, update the model
  task automatic cycle(input logic s, input logic m, input string n);
    start = s;
    MSB   = m;
    #2;
    chk(n, outs(), model(t, m));
    inv_chk(n);
    @(posedge clock);
    advance(s);
    #1;
  endtask

  // Called right after the edge that sampled start
  task automatic run_to_ready(input string n, input int msb_mode);
    for (int j = 0; j < 96; j++)
      cycle(1'b0, (msb_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(msb_mode), n);
    chk({n, "_ready_e96"}, {4'b0, ready}, 5'b00000);
    cycle(1'b0, 1'b0, n);
    chk({n, "_ready_e97"}, {4'b0, ready}, 5'b00001);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 5'b00000};
    vecs[1]  = '{1'b1, 1'b0, 5'b00000};
    vecs[2]  = '{1'b0, 1'b1, 5'b00100};
    vecs[3]  = '{1'b0, 1'b0, 5'b01000};
    vecs[4]  = '{1'b0, 1'b0, 5'b00010};
    vecs[5]  = '{1'b0, 1'b1, 5'b00100};
    vecs[6]  = '{1'b0, 1'b1, 5'b10000};
    vecs[7]  = '{1'b0, 1'b1, 5'b00000};
    vecs[8]  = '{1'b1, 1'b0, 5'b00100};
    vecs[9]  = '{1'b1, 1'b1, 5'b00100};
    vecs[10] = '{1'b0, 1'b1, 5'b00100};
    vecs[11] = '{1'b0, 1'b1, 5'b10000};

    reset = 1'b1;
    start = 1'b0;
    MSB   = 1'b0;
    #1;
    chk("reset_init", outs(), 5'b00000);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Short directed table starting from idle
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].s;
      MSB   = vecs[i].m;
      #2;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      inv_chk($sformatf("vec%0d", i));
      @(posedge clock);
      advance(vecs[i].s);
      #1;
    end

    // Asynchronous reset mid-operation with no clock edge
    #2;
    reset = 1'b1;
    #1;
    t = -1;
    chk("async_reset", outs(), 5'b00000);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, "idle_after_reset");

    // Full run with MSB held 0
    cycle(1'b1, 1'b0, "start_msb0");
    run_to_ready("full_msb0", 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "done_hold");

    // Start from DONE; MSB held 1 throughout
    cycle(1'b1, 1'b1, "start_from_done");
    chk("ready_drop", {4'b0, ready}, 5'b00000);
    run_to_ready("full_msb1", 1);

    // MSB switches 0->1 at edge E0+6
    cycle(1'b1, 1'b0, "start_switch");
    for (int j = 0; j < 3*W + 3; j++) cycle(1'b0, (j >= 6) ? 1'b1 : 1'b0, "msb_switch");

    // Restart at edge E0+40
    cycle(1'b1, 1'b0, "start_restart");
    for (int j = 0; j < 39; j++) cycle(1'b0, 1'($urandom_range(0, 1)), "pre_restart");
    cycle(1'b1, 1'b0, "restart_pulse");
    run_to_ready("restart", 2);

    // Randomized start/MSB traffic against the model
    for (int j = 0; j < 1500; j++)
      cycle(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), "random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_control_fsm.md
Name: div_control_fsm

Overview:
- Sequencing controller for the processor's multi-cycle non-restoring divider.
- Drives the remainder/quotient datapath: shift strobe, add/subtract-divisor selects and a quotient-LSB set strobe.
- Datapath feeds back the sign bit of the current partial remainder.
- Signals completion with `ready`.

Parameters:
- WIDTH, 32, number of quotient bits (iterations); legal range is WIDTH >= 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  synchronous start/restart request, sampled on each rising edge.
- MSB  input  1  sign bit of the datapath's current partial-remainder register (1 = negative).
- add  output  1  datapath adds the divisor to the remainder at the next edge.
- sub  output  1  datapath subtracts the divisor from the remainder at the next edge.
- shiftQuotient  output  1  datapath shifts {remainder, quotient} left by one at the next edge; a 0 enters the quotient LSB.
- Q0  output  1  datapath sets quotient LSB to 1 at the next edge.
- ready  output  1  division complete; quotient and remainder are final.

Behaviour:
- Reset (async, any time):
  - state = IDLE, iteration counter = 0.
  - add, sub, shiftQuotient, Q0 and ready all 0 immediately.
  - Effect is independent of clock and start.
- States:
  - IDLE
  - SHIFT, OP, SETQ: three phases per quotient bit.
  - CORRECT
  - DONE
- Counter:
  - ceil(log2(WIDTH))+1 bits.
  - Cleared on start.
  - Incremented on the SETQ->SHIFT/CORRECT transition.
- start = 1 at a rising edge, in any state:
  - next state SHIFT, counter = 0, ready = 0.
  - Restarts an operation in progress with no other effect.
  - start has priority over all other transitions.
- IDLE:
  - All outputs 0.
  - Stays in IDLE while start = 0.
- SHIFT:
  - shiftQuotient = 1; other outputs 0.
  - Next state OP.
- OP:
  - add = MSB, sub = ~MSB; these are combinational from MSB (Mealy).
  - Exactly one of add/sub is 1.
  - Next state SETQ.
- SETQ:
  - Q0 = ~MSB, combinational from the updated remainder sign.
  - Counter increments.
  - Next state SHIFT if the new count < WIDTH, else CORRECT.
- CORRECT:
  - add = MSB (restores a negative remainder); sub = 0, shiftQuotient = 0, Q0 = 0.
  - Next state DONE.
- DONE:
  - ready = 1 (registered/Moore); add, sub, shiftQuotient and Q0 all 0.
  - Holds until start or reset.
- Timing, with E0 = the edge that samples start = 1:
  - SHIFT of iteration k is active after edge E0+3k.
  - CORRECT is active after edge E0+3*WIDTH.
  - ready rises after edge E0+3*WIDTH+1; for WIDTH = 32 that is edge E0+97.
- Output invariants:
  - add and sub are never both 1.
  - shiftQuotient is never asserted together with add, sub or Q0.
  - Q0 is asserted only in SETQ.
  - No output X after reset, even if MSB is X outside OP, SETQ and CORRECT.
- start held high for several edges:
  - Each edge restarts at SHIFT with counter 0.
  - Sequencing begins from the last edge at which start = 1.

Test Plan:
- Reset: assert reset mid-operation without a clock edge -> all outputs 0 immediately; state IDLE; stays idle with start = 0.
- Full run, WIDTH = 32, MSB held 0: start high for one edge, then low.
  - Per 3-cycle group: shiftQuotient, then sub = 1, then Q0 = 1; repeated 32 times.
  - CORRECT cycle: add = 0.
  - ready = 1 from edge E0+97 and held.
- MSB held 1 throughout:
  - add = 1 in every OP; Q0 = 0 in every SETQ; add = 1 in CORRECT.
  - ready at E0+97.
- MSB switched 0->1 at edge E0+6:
  - Iterations 0-1 use sub/Q0 = 1.
  - Later iterations use add/Q0 = 0.
  - Output changes follow MSB combinationally within the OP/SETQ cycle.
- Restart: pulse start again at E0+40 -> ready stays 0; ready rises at (E0+40)+97.
- After DONE: assert start -> ready drops at the next edge and a new sequence begins.
- Invariant check every cycle: add&sub = 0, and shiftQuotient is exclusive with add, sub and Q0.
